// File: rtl/phase_sample_rom_if.sv
// Bus bundle for phase_sample_rom: address, asynchronous and registered read data.
// Build option PHASE_ROM_WR_EN adds the write data and write enable signals.
interface phase_sample_rom_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] spo;
    logic [DATA_W-1:0] qspo;
`ifdef PHASE_ROM_WR_EN
    logic [DATA_W-1:0] d;
    logic              we;
`endif

`ifdef PHASE_ROM_WR_EN
    modport master (output a, output d, output we, input spo, input qspo);
    modport slave  (input a, input d, input we, output spo, output qspo);
`else
    modport master (output a, input spo, input qspo);
    modport slave  (input a, output spo, output qspo);
`endif
endinterface

// File: rtl/phase_sample_rom.sv
// Phase-sample memory (offset binary, zero phase = 0x7FFF_FFFF) with async and registered reads.
// Build option PHASE_ROM_WR_EN adds a write port, turning the ROM into a single-port RAM.
module phase_sample_rom #(
    parameter int    ADDR_W    = 12,
    parameter int    DATA_W    = 32,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst_n,
    phase_sample_rom_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef logic [DATA_W-1:0] word_t;
    typedef word_t             mem_t [DEPTH];

    // Triangular sweep of +/-2**(DATA_W-2) around zero phase, one period per DEPTH words.
    function automatic word_t pattern_word(input logic [ADDR_W-1:0] k);
        logic [ADDR_W-2:0]        tri_v;
        logic signed [DATA_W-1:0] s;
        word_t                    zero_phase;
        tri_v      = k[ADDR_W-1] ? ~k[ADDR_W-2:0] : k[ADDR_W-2:0];
        s          = $signed(DATA_W'(tri_v) - (word_t'(1) << (ADDR_W - 2))) <<< (DATA_W - ADDR_W);
        zero_phase = {1'b0, {(DATA_W-1){1'b1}}};
        return zero_phase + word_t'(s);
    endfunction

    function automatic mem_t init_contents();
        mem_t m;
        for (int k = 0; k < DEPTH; k++) begin
            m[k] = pattern_word(k[ADDR_W-1:0]);
        end
        return m;
    endfunction

    // NOTE: contents are loaded once at configuration and deliberately have no reset;
    // clearing a memory array on reset would destroy the table and block RAM inference.
    mem_t mem_q = init_contents();

    word_t qspo_q;
    word_t qspo_d;

    assign qspo_d   = mem_q[bus.a];
    assign bus.spo  = mem_q[bus.a];
    assign bus.qspo = qspo_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; this is also what makes the registered read see pre-write data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            qspo_q <= '0;
        end else begin
            qspo_q <= qspo_d;
        end
    end

`ifdef PHASE_ROM_WR_EN
    always_ff @(posedge clk) begin
        if (rst_n && bus.we) begin
            mem_q[bus.a] <= bus.d;
        end
    end
`endif
endmodule

// File: tb/tb_phase_sample_rom.sv
// Directed self-checking bench for phase_sample_rom: pattern sweep, registered path,
// mid-sweep reset, address wrap and (with PHASE_ROM_WR_EN) write behaviour.
module tb_phase_sample_rom;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;

    logic clk = 1'b0;
    logic rst_n;

    int total = 0;
    int bad   = 0;

    phase_sample_rom_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    phase_sample_rom #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .INIT_FILE("")) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Independent model: rising ramp over the first half, falling ramp over the second.
    function automatic logic [31:0] exp_word(input int k);
        int          tri_v;
        longint      phase;
        tri_v = (k >= 2048) ? (4095 - k) : k;
        phase = longint'(tri_v - 1024) * 1048576;
        return 32'(64'd2147483647 + 64'(phase));
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int signed ph;
        logic [31:0] exp_q;

        rst_n = 1'b0;
        bus.a = '0;
`ifdef PHASE_ROM_WR_EN
        bus.d  = '0;
        bus.we = 1'b0;
`endif

        tick();
        check("reset_qspo_edge1", bus.qspo, 32'h0);
        tick();
        check("reset_qspo_edge2", bus.qspo, 32'h0);

        // Hand-computed spot values, independent of the model.
        bus.a = 12'd0;    #1 check("spot_a0",    bus.spo, 32'h3FFF_FFFF);
        bus.a = 12'd1024; #1 check("spot_a1024", bus.spo, 32'h7FFF_FFFF);
        bus.a = 12'd2047; #1 check("spot_a2047", bus.spo, 32'hBFEF_FFFF);
        bus.a = 12'd2048; #1 check("spot_a2048", bus.spo, 32'hBFEF_FFFF);
        bus.a = 12'd3071; #1 check("spot_a3071", bus.spo, 32'h7FFF_FFFF);
        bus.a = 12'd3072; #1 check("spot_a3072", bus.spo, 32'h7FEF_FFFF);
        bus.a = 12'd4095; #1 check("spot_a4095", bus.spo, 32'h3FFF_FFFF);
        bus.a = 12'd6;    #1 check("spot_a6",    bus.spo, 32'h405F_FFFF);

        // Full sweep with the registered path; reset held low for edges at a=2000,2001.
        rst_n = 1'b1;
        for (int i = 0; i < 4096; i++) begin
            bus.a = i[ADDR_W-1:0];
            rst_n = !(i == 2000 || i == 2001);
            #1;
            check($sformatf("sweep_spo_%0d", i), bus.spo, exp_word(i));
            tick();
            exp_q = rst_n ? exp_word(i) : 32'h0;
            check($sformatf("sweep_qspo_%0d", i), bus.qspo, exp_q);
            if (!rst_n) check($sformatf("reset_spo_%0d", i), bus.spo, exp_word(i));
        end
        rst_n = 1'b1;

        // Wrap 4095 -> 0: contiguous value and signed phase.
        bus.a = 12'd4095;
        #1;
        check("wrap_spo_4095", bus.spo, 32'h3FFF_FFFF);
        ph = int'(bus.spo) - 2147483647;
        check("wrap_phase_4095", 32'(ph), 32'(-1073741824));
        tick();
        bus.a = 12'd0;
        #1;
        check("wrap_spo_0", bus.spo, 32'h3FFF_FFFF);
        check("wrap_qspo_4095", bus.qspo, 32'h3FFF_FFFF);
        ph = int'(bus.spo) - 2147483647;
        check("wrap_phase_0", 32'(ph), 32'(-1073741824));
        tick();
        check("wrap_qspo_0", bus.qspo, 32'h3FFF_FFFF);

`ifdef PHASE_ROM_WR_EN
        bus.a  = 12'd5;
        bus.d  = 32'h1234_5678;
        bus.we = 1'b1;
        #1;
        check("wr_spo_before", bus.spo, exp_word(5));
        tick();
        bus.we = 1'b0;
        check("wr_spo_after", bus.spo, 32'h1234_5678);
        check("wr_qspo_readfirst", bus.qspo, exp_word(5));
        tick();
        check("wr_qspo_next", bus.qspo, 32'h1234_5678);

        bus.a  = 12'd6;
        bus.d  = 32'hDEAD_BEEF;
        bus.we = 1'b1;
        rst_n  = 1'b0;
        tick();
        bus.we = 1'b0;
        rst_n  = 1'b1;
        check("wr_in_reset_spo", bus.spo, 32'h405F_FFFF);
        check("wr_in_reset_qspo", bus.qspo, 32'h0);
        tick();
        check("wr_in_reset_qspo_next", bus.qspo, 32'h405F_FFFF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
